ps2_scan_rx: RTL and testbench
==============================

# ps2_scan_rx

PS/2 keyboard frame receiver and scan-code framer for the chess board. It sits directly upstream of the keyboard move-entry logic and drives it. It takes the raw PS/2 clock and data lines, synchronises and filters them, and deserialises 11-bit frames. It folds the E0 and F0 prefix bytes into flags and emits one strobe per complete key event, which the move-entry logic turns into `current`, `destination` and `userEn`.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- `clk` in 1: system clock. All logic runs in this single domain.
- `reset` in 1: asynchronous, active-low reset.
- `keyboardclk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `keyData` in 1: raw PS/2 data, asynchronous to `clk`.
- `code` out 8: last emitted scan code, with prefixes stripped.
- `code_valid` out 1: one-cycle strobe; `code`, `code_break` and `code_ext` are new.
- `code_break` out 1: the event was preceded by F0 (key release).
- `code_ext` out 1: the event was preceded by E0 (extended key).
- `frame_err` out 1: one-cycle strobe on a parity, start, stop or timeout error.

## Operation
- **Input conditioning**
  - `keyboardclk` and `keyData` each pass through a 2-flop synchroniser.
  - The filtered clock takes the synchronised value only after `FILTER_LEN` consecutive identical samples; otherwise it holds.
  - A falling edge of the filtered clock is the bit-sample event. `keyData` is sampled from its synchronised version on that cycle.
- **Frame FSM**: states IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample event, if data = 0 (start bit), clear the bit counter and go to DATA. If data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: record the bit. Odd parity over the 8 data bits plus the parity bit is required. Go to STOP.
  - STOP: the bit must be 1. If parity and stop are both good, the byte is accepted; otherwise `frame_err` pulses. Either way, return to IDLE.
- **Timeout**
  - In any state other than IDLE, a counter increments every `clk` and clears on each sample event.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, pulses `frame_err` and discards the partial byte.
- **Prefix handling of an accepted byte**
  - 8'hE0 sets `ext_pend`; nothing is emitted.
  - 8'hF0 sets `brk_pend`; nothing is emitted.
  - Any other byte: `code` takes the byte, `code_ext` takes `ext_pend`, `code_break` takes `brk_pend`, and `code_valid` pulses. Both pending flags then clear.
- Any `frame_err` also clears both pending flags, so a corrupted sequence never tags a later key.
- `code`, `code_break` and `code_ext` hold their values until the next emit.
- Duplicate prefixes (E0 E0, F0 F0) are idempotent.

## Timing
- Reset values:
  - FSM in IDLE; counters and pending flags at 0.
  - `code` = 8'h00; `code_valid`, `code_break`, `code_ext` and `frame_err` all 0.
  - The filtered clock resets to 1 (PS/2 idle high), so releasing reset never produces a sample event.
- Conditioning latency: a raw edge takes 2 + `FILTER_LEN` cycles to reach the filtered clock, plus 1 cycle for edge detection.
- `code_valid` and `frame_err` are registered. They assert exactly 1 `clk` after the sample event of the stop bit, or 1 cycle after the timeout count is reached.
- `code_valid` and `frame_err` are never high in the same cycle.
- Reset asserted mid-frame aborts immediately. No strobe is produced for that frame.
- A sample event on the same cycle as the timeout: timeout wins. The frame is dropped and the edge is ignored, so the frame after it resynchronises on its own start bit.

## Structure
- Package `ps2_pkg` holds:
  - the constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0;
  - the frame-state enum (IDLE, DATA, PARITY, STOP);
  - the frame length of 11.
- One sub-module, `ps2_filter`:
  - contains the synchronisers, the glitch filter and the falling-edge detector;
  - outputs `sample_en` and `sample_data`.
- The top block holds the frame FSM, the timeout counter and the prefix logic.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> one `code_valid`, `code` = 8'h1C, `code_break` = 0, `code_ext` = 0.
- Frames F0 then 1C -> exactly one `code_valid`, `code` = 8'h1C, `code_break` = 1. `frame_err` never asserts.
- Frames E0, F0, 75 -> one `code_valid`, `code` = 8'h75, `code_ext` = 1, `code_break` = 1. A following frame 75 -> `code_ext` = 0, `code_break` = 0.
- Frame 0x1C with the parity bit flipped -> `frame_err` pulses once, no `code_valid`, `code` keeps its previous value. Then F0 with a bad stop bit followed by a good 1C -> `code_break` = 0.
- Stop PS/2 clocking after 4 data bits -> `frame_err` pulses `TIMEOUT_CYCLES` + 1 cycles after the last edge. A following good 0x16 is received correctly.
- 3-cycle low glitch on `keyboardclk` (with `FILTER_LEN` = 8) -> no sample event and the FSM stays in IDLE. Separately, assert `reset` mid-frame -> all outputs return to their reset values at once, and the next good frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix bytes, frame geometry, frame-state encoding.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

    // Prefix bytes folded into flags instead of being emitted
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-flop synchronisers, clock glitch filter, falling-edge detect.
// Latency: raw clock edge -> filtered clock in 2 + FILTER_LEN cycles, sample_en one cycle later.
// Backpressure: none; sample_en is a single-cycle strobe that cannot be stalled.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_raw,
    input  logic ps2_dat_raw,
    output logic sample_en,
    output logic sample_data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          kclk_meta_q, kclk_meta_d;
    logic          kclk_sync_q, kclk_sync_d;
    logic          kdat_meta_q, kdat_meta_d;
    logic          kdat_sync_q, kdat_sync_d;
    logic [CW-1:0] filt_cnt_q,  filt_cnt_d;
    logic          filt_clk_q,  filt_clk_d;
    logic          filt_dly_q,  filt_dly_d;

    // Synchronise, then only let the filtered clock follow a run of FILTER_LEN equal samples
    always_comb begin
        kclk_meta_d = ps2_clk_raw;
        kclk_sync_d = kclk_meta_q;
        kdat_meta_d = ps2_dat_raw;
        kdat_sync_d = kdat_meta_q;
        filt_cnt_d  = '0;
        filt_clk_d  = filt_clk_q;
        if (kclk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_clk_d = kclk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        filt_dly_d = filt_clk_q;
    end

    // Lines idle high, so everything resets to 1 and reset release never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kclk_meta_q <= 1'b1;
            kclk_sync_q <= 1'b1;
            kdat_meta_q <= 1'b1;
            kdat_sync_q <= 1'b1;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_dly_q  <= 1'b1;
        end else begin
            kclk_meta_q <= kclk_meta_d;
            kclk_sync_q <= kclk_sync_d;
            kdat_meta_q <= kdat_meta_d;
            kdat_sync_q <= kdat_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            filt_dly_q  <= filt_dly_d;
        end
    end

    // Falling edge of the filtered clock is the bit-sample point
    assign sample_en   = filt_dly_q & ~filt_clk_q;
    assign sample_data = kdat_sync_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver folding E0/F0 prefixes into flags on each emitted scan code.
// Latency: code_valid / frame_err register 1 cycle after the stop-bit sample or timeout hit.
// Backpressure: none; downstream must accept every code_valid strobe as it occurs.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyboardclk,
    input  logic       keyData,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       code_break,
    output logic       code_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic sample_en;
    logic sample_data;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .rst_n       (reset),
        .ps2_clk_raw (keyboardclk),
        .ps2_dat_raw (keyData),
        .sample_en   (sample_en),
        .sample_data (sample_data)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          code_valid_q, code_valid_d;
    logic          code_break_q, code_break_d;
    logic          code_ext_q, code_ext_d;
    logic          frame_err_q, frame_err_d;

    logic          timeout_hit;
    logic          err_set;
    logic          byte_acc;

    // Timeout beats a coincident sample event: the edge is dropped along with the frame
    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

    // Frame state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state: advance one bit per sample event
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (sample_en) begin
            case (state_q)
                IDLE:    if (!sample_data) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame outputs: shift register, parity, timeout counter, prefix folding and strobes
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_d       = code_q;
        code_break_d = code_break_q;
        code_ext_d   = code_ext_q;
        err_set      = 1'b0;
        byte_acc     = 1'b0;

        if (state_q == IDLE || timeout_hit || sample_en) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            err_set = 1'b1;
        end else if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (sample_data) err_set = 1'b1;
                    else             bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {sample_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: par_ok_d = ps2_parity_ok(shift_q, sample_data);
                STOP: begin
                    if (par_ok_q && sample_data) byte_acc = 1'b1;
                    else                         err_set  = 1'b1;
                end
                default: err_set = 1'b0;
            endcase
        end

        code_valid_d = 1'b0;
        frame_err_d  = err_set;
        if (err_set) begin
            // A broken frame must not tag whatever key comes next
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_acc) begin
            if (shift_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                code_d       = shift_q;
                code_ext_d   = ext_pend_q;
                code_break_d = brk_pend_q;
                code_valid_d = 1'b1;
                ext_pend_d   = 1'b0;
                brk_pend_d   = 1'b0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            to_cnt_q     <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            code_break_q <= 1'b0;
            code_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            to_cnt_q     <= to_cnt_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            code_break_q <= code_break_d;
            code_ext_q   <= code_ext_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign code_break = code_break_q;
    assign code_ext   = code_ext_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed PS/2 frames checked against a key-event model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_scan_rx;

    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 20;

    logic       clk;
    logic       reset;
    logic       keyboardclk;
    logic       keyData;
    logic [7:0] code;
    logic       code_valid;
    logic       code_break;
    logic       code_ext;
    logic       frame_err;

    ps2_scan_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keyboardclk (keyboardclk),
        .keyData     (keyData),
        .code        (code),
        .code_valid  (code_valid),
        .code_break  (code_break),
        .code_ext    (code_ext),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_ext, m_brk;
    logic [7:0] h_code;
    bit         h_brk, h_ext;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_strobe = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    endtask

    // Key-event model: what a keyboard byte stream means, not how the receiver decodes it
    task automatic model_reset();
        exp_q.delete();
        m_ext  = 0;
        m_brk  = 0;
        h_code = 8'h00;
        h_brk  = 0;
        h_ext  = 0;
    endtask

    task automatic model_error();
        ev_t e;
        e.is_err = 1; e.code = 8'h00; e.brk = 0; e.ext = 0;
        exp_q.push_back(e);
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            model_error();
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e.is_err = 0; e.code = b; e.brk = m_brk; e.ext = m_ext;
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        keyData = b;
        wait_cyc(H);
        keyboardclk = 1'b0;
        wait_cyc(H);
        keyboardclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ flip_par;
        model_frame(b, !(flip_par || bad_stop));
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(!bad_stop);
        keyData = 1'b1;
        wait_cyc(30);
        check("strobe_arrived", exp_q.size(), 0);
    endtask

    // Compare process: every cycle, strobes against the event queue and held outputs against the model
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #2;
            if (code_valid && frame_err) fail_now("valid_and_err", 1, 0);
            if (code_valid) begin
                n_strobe++;
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    fail_now("unexpected_code_valid", int'(code), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("emit", int'({code, code_break, code_ext}), int'({e.code, e.brk, e.ext}));
                    h_code = e.code;
                    h_brk  = e.brk;
                    h_ext  = e.ext;
                end
            end
            if (frame_err) begin
                n_strobe++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) fail_now("unexpected_frame_err", 1, 0);
                else e = exp_q.pop_front();
            end
            check("held", int'({code, code_break, code_ext}), int'({h_code, h_brk, h_ext}));
        end
    end

    initial begin
        int n;
        int s0;
        keyboardclk = 1'b1;
        keyData     = 1'b1;
        reset       = 1'b0;
        model_reset();
        wait_cyc(5);
        #1;
        check("rst_code", int'(code), 'h00);
        check("rst_flags", int'({code_valid, code_break, code_ext, frame_err}), 0);
        reset = 1'b1;
        wait_cyc(30);

        // Plain make code
        send_frame(8'h1C, 0, 0);
        check("lit_1c", int'({code, code_break, code_ext}), 'h1C << 2);

        // Break prefix
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check("lit_f0_1c", int'({code, code_break, code_ext}), ('h1C << 2) | 2);

        // Extended break, then plain repeat of the same key
        send_frame(8'hE0, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("lit_e0_f0_75", int'({code, code_break, code_ext}), ('h75 << 2) | 3);
        send_frame(8'h75, 0, 0);
        check("lit_75", int'({code, code_break, code_ext}), 'h75 << 2);

        // Parity error keeps the old code; bad-stop F0 must not tag the next key
        send_frame(8'h1C, 1, 0);
        check("lit_par_err_hold", int'(code), 'h75);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 0);
        check("lit_after_bad_stop", int'({code, code_break, code_ext}), 'h1C << 2);

        // Timeout after 4 data bits (byte 0x5A), measured from the last falling edge
        model_error();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(i[0]);
        keyData = 1'b1;
        wait_cyc(H);
        keyboardclk = 1'b0;
        n = 0;
        while (n < TO + 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == H) keyboardclk = 1'b1;
            if (frame_err) break;
        end
        keyboardclk = 1'b1;
        check("timeout_latency", n, FL + TO + 4);
        wait_cyc(30);
        send_frame(8'h16, 0, 0);
        check("lit_after_timeout", int'(code), 'h16);

        // Short clock glitch must not look like a bit
        s0 = n_strobe;
        keyData = 1'b1;
        keyboardclk = 1'b0;
        wait_cyc(3);
        keyboardclk = 1'b1;
        wait_cyc(60);
        check("glitch_no_strobe", n_strobe, s0);
        send_frame(8'h2A, 0, 0);
        check("lit_after_glitch", int'(code), 'h2A);

        // Reset in the middle of a frame, with an E0 pending
        send_frame(8'hE0, 0, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_code", int'(code), 'h00);
        check("midrst_flags", int'({code_valid, code_break, code_ext, frame_err}), 0);
        wait_cyc(5);
        keyboardclk = 1'b1;
        keyData     = 1'b1;
        reset = 1'b1;
        wait_cyc(30);
        send_frame(8'h75, 0, 0);
        check("lit_after_reset", int'({code, code_break, code_ext}), 'h75 << 2);

        wait_cyc(50);
        check("final_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
